reg_array_ctrl: RTL and testbench
=================================

// Module: reg_array_ctrl
// PURPOSE
//  Window sequencer driving reg_array. Per output row, fills the register array one kernel row at a time.
//  Each kernel row is loaded from the input buffer or from the line-reuse FIFO, then shifted KSIZE-1 times.
//  Qualifies every window presented on o_pe_data to the PE array with valid/ready and (ky,kx) tags.
//  Data paths do not pass through this block; it emits reg_array_cmd and the buffer/FIFO read strobes.
// PARAMETERS
//  KSIZE   3   kernel width/height; windows per kernel row = KSIZE
//  STRIDE  1   vertical stride (1 or 2); new input rows per output row
//  ROWW    16  width of cfg_rows and row counter
// PORTS
//  clk            in   1     clock
//  rst_n          in   1     async active-low reset
//  start          in   1     pulse: begin a tile; ignored while busy=1
//  cfg_rows       in   ROWW  output rows in tile; sampled when start is accepted
//  busy           out  1     high from start accept until done
//  done           out  1     one-cycle pulse, tile finished
//  buf_rd_en      out  1     ready toward input buffer (row request)
//  buf_rd_vld     in   1     input buffer row valid on i_buf_data; transfer = en & vld
//  fifo_empty     in   1     line FIFO empty (FWFT: head valid on i_fifo_data when !empty)
//  fifo_rd_en     out  1     pop line FIFO head; only asserted with !fifo_empty
//  reg_array_cmd  out  2     00 BUFIN, 01 SHIFT, 10 FIFOI, 11 HOLD (array keeps contents)
//  pe_valid       out  1     window on o_pe_data valid
//  pe_ready       in   1     PE array accepts window
//  pe_ky          out  $clog2(KSIZE)  kernel row of presented window
//  pe_kx          out  $clog2(KSIZE)  kernel column (shift count) of presented window
//  pe_last        out  1     presented window is final of tile
// BEHAVIOUR
//  Clocking: one clock clk; reset rst_n asynchronous, active-low.
//  Reset: state IDLE, counters 0, busy/done/pe_valid/pe_last 0, pe_ky/pe_kx 0, buf_rd_en/fifo_rd_en 0, cmd HOLD.
//  adv = !pe_valid | pe_ready. The only cycles in which a non-HOLD cmd may be issued.
//  States:
//   - IDLE: start & cfg_rows!=0 -> LOAD, busy=1.
//   - IDLE: start & cfg_rows==0 -> DONE; no commands issued.
//   - LOAD: source is buffer if row==0 or ky>=KSIZE-STRIDE, else FIFO.
//     - Buffer source: buf_rd_en=adv. On transfer, cmd=BUFIN same cycle; kx=0; -> SHIFT (or stay if KSIZE==1).
//     - FIFO source: fifo_rd_en=cmd-FIFOI=adv&!fifo_empty; kx=0; -> SHIFT.
//     - Otherwise cmd=HOLD.
//   - SHIFT: when adv, cmd=SHIFT, kx++. After KSIZE-1 shifts:
//     - ky++ -> LOAD.
//     - If ky wraps: row++; if row==cfg_rows -> DRAIN, else LOAD.
//   - DRAIN: cmd=HOLD; wait until pe_valid=0 or pe_ready=1 -> DONE.
//   - DONE: done=1 for one cycle, busy=0 -> IDLE.
//  Window timing: cmd issued at edge t; the array updates at t; pe_valid=1 from t with pe_ky/pe_kx of that window.
//   - Next cmd issued in the same cycle pe_ready is high keeps pe_valid high: one window/cycle throughput.
//   - No new cmd while pe_ready is high: pe_valid drops at the next edge.
//  Stall: pe_valid & !pe_ready -> cmd=HOLD; buf_rd_en=0, fifo_rd_en=0; pe_* held stable.
//  Starvation: buffer not valid or FIFO empty in LOAD -> HOLD, no bubble beyond the wait; pe_valid drains normally.
//  pe_last=1 with window row==cfg_rows-1, ky==KSIZE-1, kx==KSIZE-1.
//  Window count per tile = cfg_rows*KSIZE*KSIZE.
//  Reads per tile:
//   - Buffer = KSIZE + (cfg_rows-1)*STRIDE.
//   - FIFO = (cfg_rows-1)*(KSIZE-STRIDE).
//  Counters compare against cfg_rows registered at start; a cfg_rows change mid-tile has no effect.
//  Reset mid-tile: immediate return to IDLE/HOLD; no done pulse.
// TESTING
//  T1 KSIZE=3,STRIDE=1,rows=2, vld/ready always 1:
//     cmd = B S S B S S B S S | F S S F S S B S S.
//     18 windows, pe_last on 18th, done 1 cycle later.
//  T2 same config, rows=2, STRIDE=2: 3 buffer reads row0; row1 ky0 from FIFO, ky1/ky2 from buffer.
//     Totals: 5 buffer, 1 FIFO.
//  T3 pe_ready low 3 cycles mid-SHIFT: cmd HOLD, pe_kx/pe_ky stable, pe_valid held; resumes with no lost/duplicated window.
//  T4 buf_rd_vld delayed 5 cycles / fifo_empty=1 4 cycles in LOAD: cmd HOLD.
//     No fifo_rd_en while empty; sequence otherwise identical to T1.
//  T5 start with cfg_rows=0: done next cycle, no cmds.
//     start while busy: ignored, window count unchanged.
//  T6 rst_n low at window 7 of T1: outputs at reset values asynchronously.
//     Fresh start afterwards reproduces T1 exactly.

Source files
------------

// File: rtl/reg_array_ctrl.sv
// rtl/reg_array_ctrl.sv - window sequencer issuing reg_array commands, read strobes and PE window tags
module reg_array_ctrl #(
    parameter int KSIZE  = 3,
    parameter int STRIDE = 1,
    parameter int ROWW   = 16,
    parameter int KW     = (KSIZE > 1) ? $clog2(KSIZE) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [ROWW-1:0] cfg_rows,
    output logic            busy,
    output logic            done,
    output logic            buf_rd_en,
    input  logic            buf_rd_vld,
    input  logic            fifo_empty,
    output logic            fifo_rd_en,
    output logic [1:0]      reg_array_cmd,
    output logic            pe_valid,
    input  logic            pe_ready,
    output logic [KW-1:0]   pe_ky,
    output logic [KW-1:0]   pe_kx,
    output logic            pe_last
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [1:0] CMD_BUFIN = 2'b00;
    localparam logic [1:0] CMD_SHIFT = 2'b01;
    localparam logic [1:0] CMD_FIFOI = 2'b10;
    localparam logic [1:0] CMD_HOLD  = 2'b11;

    localparam logic [KW-1:0] KMAX   = KW'(KSIZE - 1);
    // Kernel rows at or beyond this index are new input rows; earlier ones come from the line FIFO.
    localparam logic [KW-1:0] KREUSE = KW'(KSIZE - STRIDE);

    logic [2:0]      state;
    logic [ROWW-1:0] rows_q;
    logic [ROWW-1:0] row;
    logic [KW-1:0]   ky;
    logic [KW-1:0]   kx;

    logic            adv;
    logic            use_buf;
    logic            buf_fire;
    logic            load_fire;
    logic            shift_fire;
    logic            issue;
    logic            last_row;
    logic            krow_end;
    logic [KW-1:0]   win_kx;

    always_comb begin
        adv        = !pe_valid || pe_ready;
        last_row   = (row + ROWW'(1)) == rows_q;
        use_buf    = (row == '0) || (ky >= KREUSE);
        buf_rd_en  = (state == S_LOAD) && use_buf && adv;
        fifo_rd_en = (state == S_LOAD) && !use_buf && adv && !fifo_empty;
        buf_fire   = buf_rd_en && buf_rd_vld;
        load_fire  = buf_fire || fifo_rd_en;
        shift_fire = (state == S_SHIFT) && adv;
        issue      = load_fire || shift_fire;
        win_kx     = load_fire ? '0 : kx + KW'(1);
        krow_end   = issue && (win_kx == KMAX);

        reg_array_cmd = CMD_HOLD;
        if (buf_fire) begin
            reg_array_cmd = CMD_BUFIN;
        end else if (fifo_rd_en) begin
            reg_array_cmd = CMD_FIFOI;
        end else if (shift_fire) begin
            reg_array_cmd = CMD_SHIFT;
        end

        busy = (state == S_LOAD) || (state == S_SHIFT) || (state == S_DRAIN);
        done = (state == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            rows_q   <= '0;
            row      <= '0;
            ky       <= '0;
            kx       <= '0;
            pe_valid <= 1'b0;
            pe_ky    <= '0;
            pe_kx    <= '0;
            pe_last  <= 1'b0;
        end else begin
            // The array updates with the command, so the window tags travel with it.
            if (issue) begin
                pe_valid <= 1'b1;
                pe_ky    <= ky;
                pe_kx    <= win_kx;
                pe_last  <= last_row && (ky == KMAX) && krow_end;
            end else if (pe_ready) begin
                pe_valid <= 1'b0;
                pe_last  <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        rows_q <= cfg_rows;
                        row    <= '0;
                        ky     <= '0;
                        kx     <= '0;
                        state  <= (cfg_rows != '0) ? S_LOAD : S_DONE;
                    end
                end
                S_LOAD, S_SHIFT: begin
                    if (issue) begin
                        kx <= win_kx;
                        if (krow_end) begin
                            if (ky == KMAX) begin
                                ky    <= '0;
                                row   <= row + ROWW'(1);
                                state <= last_row ? S_DRAIN : S_LOAD;
                            end else begin
                                ky    <= ky + KW'(1);
                                state <= S_LOAD;
                            end
                        end else begin
                            state <= S_SHIFT;
                        end
                    end
                end
                S_DRAIN: begin
                    if (adv) begin
                        state <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_reg_array_ctrl.sv
// tb/tb_reg_array_ctrl.sv - table-driven and randomized checks of reg_array_ctrl against a tile model
`timescale 1ns/1ps
module tb_reg_array_ctrl;
    localparam int K = 3;
    localparam logic [1:0] C_B = 2'b00;
    localparam logic [1:0] C_F = 2'b10;
    localparam logic [1:0] C_H = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        start2 = 1'b0;
    logic [15:0] cfg_rows = '0;
    logic        buf_rd_vld = 1'b1;
    logic        fifo_empty = 1'b0;
    logic        pe_ready = 1'b1;

    logic        busy, done, buf_rd_en, fifo_rd_en, pe_valid, pe_last;
    logic [1:0]  cmd, pe_ky, pe_kx;
    logic        busy2, done2, buf_rd_en2, fifo_rd_en2, pe_valid2, pe_last2;
    logic [1:0]  cmd2, pe_ky2, pe_kx2;

    always #5 clk = ~clk;

    reg_array_ctrl #(.KSIZE(3), .STRIDE(1), .ROWW(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_rows(cfg_rows),
        .busy(busy), .done(done), .buf_rd_en(buf_rd_en), .buf_rd_vld(buf_rd_vld),
        .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .reg_array_cmd(cmd),
        .pe_valid(pe_valid), .pe_ready(pe_ready), .pe_ky(pe_ky), .pe_kx(pe_kx),
        .pe_last(pe_last)
    );

    reg_array_ctrl #(.KSIZE(3), .STRIDE(2), .ROWW(16)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .cfg_rows(cfg_rows),
        .busy(busy2), .done(done2), .buf_rd_en(buf_rd_en2), .buf_rd_vld(buf_rd_vld),
        .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en2), .reg_array_cmd(cmd2),
        .pe_valid(pe_valid2), .pe_ready(pe_ready), .pe_ky(pe_ky2), .pe_kx(pe_kx2),
        .pe_last(pe_last2)
    );

    typedef struct {
        int rows; int ready_pct; int vld_pct; int empty_pct;
        int stall_at; int stall_len; int hold_at; int hold_len; int restart_at;
        int exp_wins; int exp_buf; int exp_fifo;
    } vec_t;

    vec_t vecs[10];
    int n_cmp = 0, n_fail = 0, cyc = 0;
    int ready_pct = 100, vld_pct = 100, empty_pct = 0;
    int stall_from = -1, stall_to = -1, hold_from = -1, hold_to = -1;
    bit scramble = 1'b0;
    int cmd_log[$], cmd_cyc[$], win_log[$], win_cyc[$], done_cyc[$], cmd2_log[$];
    int exp_cmd[$], exp_win[$];
    int nbuf = 0, nfifo = 0, nbuf2 = 0, nfifo2 = 0, ndone2 = 0;
    bit prev_stall = 1'b0;
    int prev_tags = 0;
    int last_s, last_bc, last_bw, last_bd;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int tags();
        return int'({pe_valid, pe_ky, pe_kx, pe_last});
    endfunction

    // Expected tile behaviour: each kernel row is one load followed by K-1 shifts.
    task automatic build_exp(input int rows, input int stride);
        exp_cmd.delete();
        exp_win.delete();
        for (int r = 0; r < rows; r++) begin
            for (int ky = 0; ky < K; ky++) begin
                exp_cmd.push_back((r == 0 || ky >= K - stride) ? 0 : 2);
                for (int s = 1; s < K; s++) exp_cmd.push_back(1);
                for (int kx = 0; kx < K; kx++)
                    exp_win.push_back(ky * 256 + kx * 16 +
                                      ((r == rows - 1 && ky == K - 1 && kx == K - 1) ? 1 : 0));
            end
        end
    endtask

    task automatic sample();
        bit adv;
        adv = !pe_valid || pe_ready;
        if (rst_n) begin
            if (cmd != C_H) begin
                cmd_log.push_back(int'(cmd));
                cmd_cyc.push_back(cyc);
                chk("cmd_needs_adv", int'(adv), 1);
            end
            if (busy) begin
                chk("bufin_iff_transfer", int'(cmd == C_B), int'(buf_rd_en && buf_rd_vld));
                chk("fifoi_iff_pop", int'(cmd == C_F), int'(fifo_rd_en));
            end
            if (fifo_rd_en) chk("pop_while_empty", int'(fifo_empty), 0);
            if (prev_stall) chk("stall_hold_tags", tags(), prev_tags);
            if (buf_rd_en && buf_rd_vld) nbuf++;
            if (fifo_rd_en) nfifo++;
            if (pe_valid && pe_ready) begin
                win_log.push_back(int'(pe_ky) * 256 + int'(pe_kx) * 16 + int'(pe_last));
                win_cyc.push_back(cyc);
            end
            if (done) done_cyc.push_back(cyc);
            if (cmd2 != C_H) cmd2_log.push_back(int'(cmd2));
            if (buf_rd_en2 && buf_rd_vld) nbuf2++;
            if (fifo_rd_en2) nfifo2++;
            if (done2) ndone2++;
        end
        prev_stall = rst_n && pe_valid && !pe_ready;
        prev_tags  = tags();
    endtask

    task automatic drive();
        pe_ready   = (cyc >= stall_from && cyc < stall_to) ? 1'b0
                   : (int'($urandom_range(99)) < ready_pct);
        buf_rd_vld = (cyc >= hold_from && cyc < hold_to) ? 1'b0
                   : (int'($urandom_range(99)) < vld_pct);
        fifo_empty = (cyc >= hold_from && cyc < hold_to) ? 1'b1
                   : (int'($urandom_range(99)) < empty_pct);
        if (scramble) cfg_rows = 16'($urandom);
    endtask

    task automatic step();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        cyc++;
        drive();
    endtask

    task automatic run_tile(input vec_t v);
        int bc, bw, bd, nb0, nf0, t, mis;
        bc = cmd_log.size(); bw = win_log.size(); bd = done_cyc.size();
        nb0 = nbuf; nf0 = nfifo;
        ready_pct = v.ready_pct; vld_pct = v.vld_pct; empty_pct = v.empty_pct;
        last_s = cyc; last_bc = bc; last_bw = bw; last_bd = bd;
        stall_from = (v.stall_len > 0) ? cyc + v.stall_at : -1;
        stall_to   = stall_from + v.stall_len;
        hold_from  = (v.hold_len > 0) ? cyc + v.hold_at : -1;
        hold_to    = hold_from + v.hold_len;
        build_exp(v.rows, 1);
        cfg_rows = 16'(v.rows);
        start = 1'b1;
        step();
        start = 1'b0;
        scramble = 1'b1;
        t = 0;
        while (done_cyc.size() == bd && t < 4000) begin
            start = (t == v.restart_at);
            step();
            t++;
        end
        start = 1'b0;
        scramble = 1'b0;
        chk("done_seen", int'(done_cyc.size() > bd), 1);
        chk("pe_valid_after_done", int'(pe_valid), 0);
        chk("busy_after_done", int'(busy), 0);
        if (v.rows == 0 && done_cyc.size() > bd) chk("zero_rows_done_latency", done_cyc[bd] - last_s, 1);
        chk("cmd_count", cmd_log.size() - bc, exp_cmd.size());
        mis = -1;
        for (int i = 0; i < exp_cmd.size(); i++)
            if (mis < 0 && bc + i < cmd_log.size() && cmd_log[bc + i] != exp_cmd[i]) mis = i;
        chk("cmd_seq_first_diff", mis, -1);
        chk("window_count", win_log.size() - bw, v.exp_wins);
        mis = -1;
        for (int i = 0; i < exp_win.size(); i++)
            if (mis < 0 && bw + i < win_log.size() && win_log[bw + i] != exp_win[i]) mis = i;
        chk("window_tags_first_diff", mis, -1);
        chk("buf_reads", nbuf - nb0, v.exp_buf);
        chk("fifo_reads", nfifo - nf0, v.exp_fifo);
        ready_pct = 100; vld_pct = 100; empty_pct = 0;
        stall_from = -1; stall_to = -1; hold_from = -1; hold_to = -1;
        step();
    endtask

    task automatic t1_timing();
        chk("t1_logs_complete", int'(cmd_log.size() >= last_bc + 18 &&
            win_log.size() >= last_bw + 18 && done_cyc.size() > last_bd), 1);
        if (cmd_log.size() >= last_bc + 18 && win_log.size() >= last_bw + 18 && done_cyc.size() > last_bd) begin
            chk("t1_first_cmd_cycle", cmd_cyc[last_bc] - last_s, 1);
            chk("t1_no_bubbles", cmd_cyc[last_bc + 17] - cmd_cyc[last_bc], 17);
            chk("t1_done_after_last", done_cyc[last_bd] - win_cyc[last_bw + 17], 1);
        end
    endtask

    initial begin
        int t, bc, bw, nb, nf, nd, mis;
        vec_t rv;
        vecs[0] = '{2, 100, 100, 0,   0, 0,  0, 0, -1,  18, 4, 2};
        vecs[1] = '{1, 100, 100, 0,   0, 0,  0, 0, -1,   9, 3, 0};
        vecs[2] = '{3,  60,  70, 30,  0, 0,  0, 0, -1,  27, 5, 4};
        vecs[3] = '{5,  40,  50, 50,  0, 0,  0, 0, -1,  45, 7, 8};
        vecs[4] = '{2, 100, 100, 0,   5, 3,  0, 0, -1,  18, 4, 2};
        vecs[5] = '{2, 100, 100, 0,   0, 0,  1, 5, -1,  18, 4, 2};
        vecs[6] = '{2, 100, 100, 0,   0, 0,  9, 5, -1,  18, 4, 2};
        vecs[7] = '{0, 100, 100, 0,   0, 0,  0, 0, -1,   0, 0, 0};
        vecs[8] = '{4,  70,  70, 20,  0, 0,  0, 0,  6,  36, 6, 6};
        vecs[9] = '{3,  50,  50, 50,  0, 0,  0, 0, -1,  27, 5, 4};

        #2 rst_n = 1'b0;
        #1;
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_pe_valid", int'(pe_valid), 0);
        chk("reset_cmd", int'(cmd), 3);
        chk("reset_strobes", int'({buf_rd_en, fifo_rd_en}), 0);
        chk("reset_tags", int'({pe_ky, pe_kx, pe_last}), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        step();

        run_tile(vecs[0]);
        t1_timing();
        for (int i = 1; i < 10; i++) run_tile(vecs[i]);

        for (int i = 0; i < 4; i++) begin
            rv.rows = int'($urandom_range(1, 6));
            rv.ready_pct = int'($urandom_range(30, 100));
            rv.vld_pct = int'($urandom_range(30, 100));
            rv.empty_pct = int'($urandom_range(0, 60));
            rv.stall_at = 0; rv.stall_len = 0; rv.hold_at = 0; rv.hold_len = 0; rv.restart_at = -1;
            rv.exp_wins = rv.rows * K * K;
            rv.exp_buf = K + (rv.rows - 1);
            rv.exp_fifo = (rv.rows - 1) * (K - 1);
            run_tile(rv);
        end

        // Stride-2 instance: row 1 reuses only kernel row 0 from the FIFO.
        build_exp(2, 2);
        bc = cmd2_log.size(); nb = nbuf2; nf = nfifo2; nd = ndone2;
        cfg_rows = 16'd2;
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        t = 0;
        while (ndone2 == nd && t < 200) begin step(); t++; end
        chk("t2_done", ndone2 - nd, 1);
        chk("t2_cmd_count", cmd2_log.size() - bc, exp_cmd.size());
        mis = -1;
        for (int i = 0; i < exp_cmd.size(); i++)
            if (mis < 0 && bc + i < cmd2_log.size() && cmd2_log[bc + i] != exp_cmd[i]) mis = i;
        chk("t2_cmd_seq_first_diff", mis, -1);
        chk("t2_buf_reads", nbuf2 - nb, 5);
        chk("t2_fifo_reads", nfifo2 - nf, 1);
        step();

        // Reset in the middle of the seventh window.
        cfg_rows = 16'd2;
        start = 1'b1;
        step();
        start = 1'b0;
        bw = win_log.size();
        t = 0;
        while (win_log.size() - bw < 7 && t < 100) begin step(); t++; end
        chk("t6_reached_window7", win_log.size() - bw, 7);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_busy", int'(busy), 0);
        chk("t6_pe_valid", int'(pe_valid), 0);
        chk("t6_cmd", int'(cmd), 3);
        chk("t6_strobes", int'({buf_rd_en, fifo_rd_en}), 0);
        chk("t6_tags", int'({pe_ky, pe_kx, pe_last}), 0);
        nd = done_cyc.size();
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("t6_no_done_pulse", done_cyc.size() - nd, 0);
        run_tile(vecs[0]);
        t1_timing();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
